// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/stop bubbles and debug counters.
// Latency: one cycle from ID inputs to EX outputs; stall_o is combinational in the same cycle.
// Backpressure: none from EX; stall_o asks IF/ID to hold while a bubble is injected.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid_i,
  input  logic [13:0]       id_ctrl_i,
  input  logic [4:0]        id_rs1_addr_i,
  input  logic [4:0]        id_rs2_addr_i,
  input  logic [4:0]        id_rd_addr_i,
  input  logic [9:0]        id_funct_i,
  input  logic [DATA_W-1:0] id_rs1_data_i,
  input  logic [DATA_W-1:0] id_rs2_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [DATA_W-1:0] id_pc_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  output logic [13:0]       ex_ctrl_o,
  output logic [4:0]        ex_rs1_addr_o,
  output logic [4:0]        ex_rs2_addr_o,
  output logic [4:0]        ex_rd_addr_o,
  output logic [9:0]        ex_funct_o,
  output logic [DATA_W-1:0] ex_rs1_data_o,
  output logic [DATA_W-1:0] ex_rs2_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [DATA_W-1:0] ex_pc_o,
  output logic              stall_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  // Control word bit positions used locally.
  localparam int CTRL_MEM_TO_REG = 0;
  localparam int CTRL_RS1_USE    = 10;
  localparam int CTRL_RS2_USE    = 11;
  localparam int CTRL_STOP       = 12;

  logic              r_valid;
  logic [13:0]       r_ctrl;
  logic [4:0]        r_rs1_addr;
  logic [4:0]        r_rs2_addr;
  logic [4:0]        r_rd_addr;
  logic [9:0]        r_funct;
  logic [DATA_W-1:0] r_rs1_data;
  logic [DATA_W-1:0] r_rs2_data;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc;
  logic              r_halted;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_hit;
  logic w_load_use;
  logic w_stall;
  logic w_capture;
  logic w_flush_evt;

  // Hazard detection: a load in EX whose rd (non-x0) feeds a source the ID instruction actually reads.
  always_comb begin
    w_hit = (id_ctrl_i[CTRL_RS1_USE] && (id_rs1_addr_i == r_rd_addr)) ||
            (id_ctrl_i[CTRL_RS2_USE] && (id_rs2_addr_i == r_rd_addr));
    w_load_use = r_valid && r_ctrl[CTRL_MEM_TO_REG] && (r_rd_addr != 5'd0) &&
                 id_valid_i && w_hit;
    // A flush or a stopped program makes holding IF/ID pointless.
    w_stall     = w_load_use && !flush_i && !r_halted;
    // Priority: flush, halted, load-use, then a valid ID instruction.
    w_capture   = !flush_i && !r_halted && !w_load_use && id_valid_i;
    w_flush_evt = flush_i && id_valid_i;
  end

  // Valid/control path: capture or inject a bubble; stop flag latches halted on capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_halted <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_ctrl  <= id_ctrl_i;
      if (id_ctrl_i[CTRL_STOP]) begin
        r_halted <= 1'b1;
      end
    end else begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end
  end

  // Datapath registers load only on capture; bubbles leave the old values in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_funct    <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
    end else if (w_capture) begin
      r_rs1_addr <= id_rs1_addr_i;
      r_rs2_addr <= id_rs2_addr_i;
      r_rd_addr  <= id_rd_addr_i;
      r_funct    <= id_funct_i;
      r_rs1_data <= id_rs1_data_i;
      r_rs2_data <= id_rs2_data_i;
      r_imm      <= id_imm_i;
      r_pc       <= id_pc_i;
    end
  end

  // Saturating event counters for debug visibility.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_evt && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign ex_valid_o    = r_valid;
  assign ex_ctrl_o     = r_ctrl;
  assign ex_rs1_addr_o = r_rs1_addr;
  assign ex_rs2_addr_o = r_rs2_addr;
  assign ex_rd_addr_o  = r_rd_addr;
  assign ex_funct_o    = r_funct;
  assign ex_rs1_data_o = r_rs1_data;
  assign ex_rs2_data_o = r_rs2_data;
  assign ex_imm_o      = r_imm;
  assign ex_pc_o       = r_pc;
  assign stall_o       = w_stall;
  assign halted_o      = r_halted;
  assign stall_cnt_o   = r_stall_cnt;
  assign flush_cnt_o   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a 16-bit-counter instance and a 2-bit-counter instance share stimulus.
module tb_id_ex_stage;

  localparam logic [13:0] C_LW    = 14'h0461; // mem_to_reg, rd_we, alu_src_b, rs1_in_use
  localparam logic [13:0] C_ADD   = 14'h0C20; // rd_we, rs1_in_use, rs2_in_use
  localparam logic [13:0] C_ADDI  = 14'h0460; // rd_we, alu_src_b, rs1_in_use
  localparam logic [13:0] C_ECALL = 14'h1000; // stop_flag

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid_i;
  logic [13:0] id_ctrl_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic [9:0]  id_funct_i;
  logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i;
  logic        flush_i;

  logic        ex_valid_o, stall_o, halted_o;
  logic [13:0] ex_ctrl_o;
  logic [4:0]  ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o;
  logic [9:0]  ex_funct_o;
  logic [31:0] ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  logic        b_ex_valid_o, b_stall_o, b_halted_o;
  logic [13:0] b_ex_ctrl_o;
  logic [4:0]  b_ex_rs1_addr_o, b_ex_rs2_addr_o, b_ex_rd_addr_o;
  logic [9:0]  b_ex_funct_o;
  logic [31:0] b_ex_rs1_data_o, b_ex_rs2_data_o, b_ex_imm_o, b_ex_pc_o;
  logic [1:0]  b_stall_cnt_o, b_flush_cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .id_funct_i(id_funct_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_pc_i(id_pc_i), .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o), .ex_rs1_addr_o(ex_rs1_addr_o),
    .ex_rs2_addr_o(ex_rs2_addr_o), .ex_rd_addr_o(ex_rd_addr_o), .ex_funct_o(ex_funct_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o),
    .ex_pc_o(ex_pc_o), .stall_o(stall_o), .halted_o(halted_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  id_ex_stage #(.DATA_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .id_funct_i(id_funct_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_pc_i(id_pc_i), .flush_i(flush_i),
    .ex_valid_o(b_ex_valid_o), .ex_ctrl_o(b_ex_ctrl_o), .ex_rs1_addr_o(b_ex_rs1_addr_o),
    .ex_rs2_addr_o(b_ex_rs2_addr_o), .ex_rd_addr_o(b_ex_rd_addr_o), .ex_funct_o(b_ex_funct_o),
    .ex_rs1_data_o(b_ex_rs1_data_o), .ex_rs2_data_o(b_ex_rs2_data_o), .ex_imm_o(b_ex_imm_o),
    .ex_pc_o(b_ex_pc_o), .stall_o(b_stall_o), .halted_o(b_halted_o),
    .stall_cnt_o(b_stall_cnt_o), .flush_cnt_o(b_flush_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one ID instruction; data fields are derived from the PC so captures are traceable.
  task automatic set_id(input logic v, input logic [13:0] c, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] d, input logic [31:0] pc);
    id_valid_i    = v;
    id_ctrl_i     = c;
    id_rs1_addr_i = a1;
    id_rs2_addr_i = a2;
    id_rd_addr_i  = d;
    id_funct_i    = 10'h0;
    id_rs1_data_i = pc ^ 32'hA5A5_0000;
    id_rs2_data_i = ~pc;
    id_imm_i      = pc + 32'd4;
    id_pc_i       = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    flush_i = 1'b0;
    set_id(1'b0, 14'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    #2;
    chk("rst_valid", 64'(ex_valid_o), 64'h0);
    chk("rst_ctrl", 64'(ex_ctrl_o), 64'h0);
    chk("rst_halted", 64'(halted_o), 64'h0);
    chk("rst_stall_cnt", 64'(stall_cnt_o), 64'h0);
    chk("rst_flush_cnt", 64'(flush_cnt_o), 64'h0);
    chk("rst_stall", 64'(stall_o), 64'h0);
    tick();
    reset = 1'b1;

    // 1: LW x5 then ADD using x5 -> one stall cycle and one bubble.
    set_id(1'b1, C_LW, 5'd1, 5'd0, 5'd5, 32'h100);
    #1 chk("t1_lw_nostall", 64'(stall_o), 64'h0);
    tick();
    chk("t1_lw_valid", 64'(ex_valid_o), 64'h1);
    chk("t1_lw_ctrl", 64'(ex_ctrl_o), 64'(C_LW));
    chk("t1_lw_rd", 64'(ex_rd_addr_o), 64'd5);
    chk("t1_lw_rs1d", 64'(ex_rs1_data_o), 64'h A5A5_0100);
    set_id(1'b1, C_ADD, 5'd5, 5'd6, 5'd7, 32'h104);
    #1 chk("t1_stall", 64'(stall_o), 64'h1);
    tick();
    chk("t1_bubble_valid", 64'(ex_valid_o), 64'h0);
    chk("t1_bubble_ctrl", 64'(ex_ctrl_o), 64'h0);
    chk("t1_bubble_pc_hold", 64'(ex_pc_o), 64'h100);
    chk("t1_stall_cnt", 64'(stall_cnt_o), 64'd1);
    chk("t1_stall_released", 64'(stall_o), 64'h0);
    tick();
    chk("t1_add_valid", 64'(ex_valid_o), 64'h1);
    chk("t1_add_pc", 64'(ex_pc_o), 64'h104);
    chk("t1_add_imm", 64'(ex_imm_o), 64'h108);
    chk("t1_add_rs1a", 64'(ex_rs1_addr_o), 64'd5);

    // 2: x0 destination and unused rs2 field never stall.
    set_id(1'b1, C_LW, 5'd1, 5'd0, 5'd0, 32'h108);
    tick();
    set_id(1'b1, C_ADD, 5'd0, 5'd0, 5'd9, 32'h10C);
    #1 chk("t2_x0_nostall", 64'(stall_o), 64'h0);
    tick();
    chk("t2_x0_pc", 64'(ex_pc_o), 64'h10C);
    set_id(1'b1, C_LW, 5'd1, 5'd0, 5'd5, 32'h110);
    tick();
    set_id(1'b1, C_ADDI, 5'd2, 5'd5, 5'd8, 32'h114);
    #1 chk("t2_rs2unused_nostall", 64'(stall_o), 64'h0);
    tick();
    chk("t2_addi_valid", 64'(ex_valid_o), 64'h1);
    chk("t2_addi_pc", 64'(ex_pc_o), 64'h114);
    chk("t2_stall_cnt", 64'(stall_cnt_o), 64'd1);

    // 3: flush during a load-use hazard.
    set_id(1'b1, C_LW, 5'd1, 5'd0, 5'd5, 32'h118);
    tick();
    set_id(1'b1, C_ADD, 5'd5, 5'd6, 5'd7, 32'h11C);
    flush_i = 1'b1;
    #1 chk("t3_flush_nostall", 64'(stall_o), 64'h0);
    tick();
    flush_i = 1'b0;
    chk("t3_flush_valid", 64'(ex_valid_o), 64'h0);
    chk("t3_flush_cnt", 64'(flush_cnt_o), 64'd1);
    chk("t3_stall_cnt", 64'(stall_cnt_o), 64'd1);
    tick();
    chk("t3_after_flush_pc", 64'(ex_pc_o), 64'h11C);

    // 6: four more load-use stalls, five in total; the 2-bit counter pins at 3.
    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, C_LW, 5'd1, 5'd0, 5'd9, 32'h120 + 32'(i * 8));
      tick();
      set_id(1'b1, C_ADD, 5'd3, 5'd9, 5'd10, 32'h124 + 32'(i * 8));
      #1 chk("t6_stall", 64'(stall_o), 64'h1);
      tick();
      tick();
    end
    chk("t6_stall_cnt16", 64'(stall_cnt_o), 64'd5);
    chk("t6_stall_cnt2_sat", 64'(b_stall_cnt_o), 64'd3);
    chk("t6_add_pc", 64'(ex_pc_o), 64'h13C);

    // Flush together with a stop in ID: flush wins and nothing halts.
    set_id(1'b1, C_ECALL, 5'd0, 5'd0, 5'd0, 32'h1F0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t4_flush_stop_halted", 64'(halted_o), 64'h0);
    chk("t4_flush_stop_valid", 64'(ex_valid_o), 64'h0);
    chk("t4_flush_cnt", 64'(flush_cnt_o), 64'd2);

    // 4: ECALL reaches EX and halts; later instructions become bubbles.
    set_id(1'b1, C_ECALL, 5'd0, 5'd0, 5'd0, 32'h200);
    tick();
    chk("t4_halted", 64'(halted_o), 64'h1);
    chk("t4_ecall_valid", 64'(ex_valid_o), 64'h1);
    chk("t4_ecall_ctrl", 64'(ex_ctrl_o), 64'(C_ECALL));
    set_id(1'b1, C_ADD, 5'd1, 5'd2, 5'd3, 32'h204);
    tick();
    chk("t4_add_blocked", 64'(ex_valid_o), 64'h0);
    tick();
    chk("t4_add_blocked2", 64'(ex_valid_o), 64'h0);
    chk("t4_halted_hold", 64'(halted_o), 64'h1);
    chk("t4_pc_hold", 64'(ex_pc_o), 64'h200);

    // 5: reset clears halted, then an asynchronous reset with a valid EX instruction.
    reset = 1'b0;
    #1 chk("t5_halt_cleared", 64'(halted_o), 64'h0);
    reset = 1'b1;
    set_id(1'b1, C_ADD, 5'd1, 5'd2, 5'd3, 32'h300);
    tick();
    chk("t5_valid", 64'(ex_valid_o), 64'h1);
    chk("t5_pc", 64'(ex_pc_o), 64'h300);
    chk("t5_cnt_cleared", 64'(stall_cnt_o), 64'd0);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_valid", 64'(ex_valid_o), 64'h0);
    chk("t5_async_ctrl", 64'(ex_ctrl_o), 64'h0);
    chk("t5_async_pc", 64'(ex_pc_o), 64'h0);
    chk("t5_async_rs2d", 64'(ex_rs2_data_o), 64'h0);
    chk("t5_async_flush_cnt", 64'(flush_cnt_o), 64'h0);
    #1 reset = 1'b1;
    tick();
    chk("t5_resume_valid", 64'(ex_valid_o), 64'h1);
    chk("t5_resume_rs2d", 64'(ex_rs2_data_o), 64'hFFFF_FCFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
